// File: rtl/fu_lsu.sv
// Load/store unit: a one-slot issue stage feeding memory, plus an in-order tracking FIFO
// that pairs each memory response with the operation that issued it.
module fu_lsu #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned TAG_W  = 6,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_op,
    input  logic [31:0]       in_base,
    input  logic [31:0]       in_imm,
    input  logic [31:0]       in_sdata,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              in_rf_we,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_rdata,
    output logic              out_valid,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_rf_we,
    output logic [31:0]       out_wdata,
    output logic [1:0]        out_exc
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Stage A
    logic              a_valid;
    logic [7:0]        a_op;
    logic [TAG_W-1:0]  a_tag;
    logic              a_rf_we;
    logic [31:0]       a_sdata;
    logic [ADDR_W-1:0] a_vaddr;

    logic [31:0]       vaddr_sum;
    logic              a_byte, a_half, a_word, a_load, a_store, a_mis;
    logic [3:0]        a_be;
    logic              fifo_full, fifo_empty;
    logic              req_fire, exc_leave, a_leave, pop;

    // Tracking FIFO
    logic [TAG_W-1:0]  f_tag   [DEPTH];
    logic [7:0]        f_op    [DEPTH];
    logic [3:0]        f_be    [DEPTH];
    logic              f_rf_we [DEPTH];
    logic [DEPTH-1:0]  f_kill;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;

    logic [7:0]        h_op;
    logic [3:0]        h_be;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_data;

    assign vaddr_sum = in_base + in_imm;

    assign a_byte  = a_op[7] | a_op[6] | a_op[2];
    assign a_half  = a_op[5] | a_op[4] | a_op[1];
    assign a_word  = a_op[3] | a_op[0];
    assign a_load  = |a_op[7:3];
    assign a_store = |a_op[2:0];
    assign a_mis   = (a_half & a_vaddr[0]) | (a_word & (a_vaddr[1:0] != 2'b00));

    always_comb begin
        a_be = 4'b0000;
        if (a_byte) begin
            a_be = 4'b0001 << a_vaddr[1:0];
        end else if (a_half) begin
            a_be = a_vaddr[1] ? 4'b1100 : 4'b0011;
        end else if (a_word) begin
            a_be = 4'b1111;
        end
    end

    always_comb begin
        mem_wdata = 32'd0;
        if (a_op[2]) begin
            mem_wdata = {4{a_sdata[7:0]}};
        end else if (a_op[1]) begin
            mem_wdata = {2{a_sdata[15:0]}};
        end else if (a_op[0]) begin
            mem_wdata = a_sdata;
        end
    end

    assign fifo_full  = (count == CNT_W'(DEPTH));
    assign fifo_empty = (count == '0);

    assign mem_req_valid = a_valid & ~a_mis & ~fifo_full & ~flush;
    assign mem_we        = a_store ? a_be : 4'b0000;
    assign mem_addr      = a_vaddr;
    assign req_fire      = mem_req_valid & mem_req_ready;
    // A misaligned op retires only once everything older has drained, keeping results in order.
    assign exc_leave     = a_valid & a_mis & fifo_empty & ~flush;
    assign a_leave       = req_fire | exc_leave;
    assign in_ready      = ~flush & (~a_valid | a_leave);
    assign pop           = mem_resp_valid & ~fifo_empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_valid <= 1'b0;
            a_op    <= '0;
            a_tag   <= '0;
            a_rf_we <= 1'b0;
            a_sdata <= '0;
            a_vaddr <= '0;
        end else if (flush) begin
            a_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            a_valid <= 1'b1;
            a_op    <= in_op;
            a_tag   <= in_tag;
            a_rf_we <= in_rf_we;
            a_sdata <= in_sdata;
            a_vaddr <= ADDR_W'(vaddr_sum);
        end else if (a_leave) begin
            a_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            f_kill <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                f_tag[i]   <= '0;
                f_op[i]    <= '0;
                f_be[i]    <= '0;
                f_rf_we[i] <= 1'b0;
            end
        end else begin
            if (req_fire) begin
                f_tag[wr_ptr]   <= a_tag;
                f_op[wr_ptr]    <= a_op;
                f_be[wr_ptr]    <= a_be;
                f_rf_we[wr_ptr] <= a_rf_we;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (flush) begin
                f_kill <= '1;
            end else if (req_fire) begin
                f_kill[wr_ptr] <= 1'b0;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (req_fire && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!req_fire && pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign h_op = f_op[rd_ptr];
    assign h_be = f_be[rd_ptr];

    always_comb begin
        case (h_be)
            4'b0010: rd_byte = mem_rdata[15:8];
            4'b0100: rd_byte = mem_rdata[23:16];
            4'b1000: rd_byte = mem_rdata[31:24];
            default: rd_byte = mem_rdata[7:0];
        endcase
        rd_half = h_be[2] ? mem_rdata[31:16] : mem_rdata[15:0];
    end

    always_comb begin
        load_data = 32'd0;
        if (h_op[7]) begin
            load_data = {{24{rd_byte[7]}}, rd_byte};
        end else if (h_op[6]) begin
            load_data = {24'd0, rd_byte};
        end else if (h_op[5]) begin
            load_data = {{16{rd_half[15]}}, rd_half};
        end else if (h_op[4]) begin
            load_data = {16'd0, rd_half};
        end else if (h_op[3]) begin
            load_data = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_tag   <= '0;
            out_rf_we <= 1'b0;
            out_wdata <= '0;
            out_exc   <= 2'b00;
        end else begin
            out_valid <= 1'b0;
            out_tag   <= '0;
            out_rf_we <= 1'b0;
            out_wdata <= '0;
            out_exc   <= 2'b00;
            if (pop && !f_kill[rd_ptr] && !flush) begin
                out_valid <= 1'b1;
                out_tag   <= f_tag[rd_ptr];
                out_rf_we <= (|h_op[7:3]) & f_rf_we[rd_ptr];
                out_wdata <= load_data;
            end else if (exc_leave) begin
                out_valid <= 1'b1;
                out_tag   <= a_tag;
                out_wdata <= 32'(a_vaddr);
                out_exc   <= a_load ? 2'b01 : 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_fu_lsu.sv
// Bench for fu_lsu: transaction-level model with a response queue, directed scenarios
// pinned by literal expectations, then a randomized run checked every cycle.
module tb_fu_lsu;
    localparam int DEPTH = 4;
    localparam logic [7:0] LB = 8'h80, LBU = 8'h40, LH = 8'h20, LHU = 8'h10, LW = 8'h08;
    localparam logic [7:0] SB = 8'h04, SH = 8'h02, SW = 8'h01;

    logic        clk, resetn, flush, in_valid, in_ready, in_rf_we;
    logic [7:0]  in_op;
    logic [31:0] in_base, in_imm, in_sdata;
    logic [5:0]  in_tag;
    logic        mem_req_valid, mem_req_ready, mem_resp_valid;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        out_valid, out_rf_we;
    logic [5:0]  out_tag;
    logic [31:0] out_wdata;
    logic [1:0]  out_exc;

    fu_lsu #(.ADDR_W(32), .TAG_W(6), .DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_base(in_base),
        .in_imm(in_imm), .in_sdata(in_sdata), .in_tag(in_tag), .in_rf_we(in_rf_we),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid),
        .mem_rdata(mem_rdata), .out_valid(out_valid), .out_tag(out_tag),
        .out_rf_we(out_rf_we), .out_wdata(out_wdata), .out_exc(out_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] tag;
        logic [7:0] op;
        logic [1:0] off;
        logic       rf_we;
        logic       kill;
    } ent_t;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int memq[$];
    ent_t m_q[$];

    logic        m_a_valid, m_a_rf_we;
    logic [7:0]  m_a_op;
    logic [5:0]  m_a_tag;
    logic [31:0] m_a_sdata, m_a_vaddr;
    logic        m_ov, m_orfwe;
    logic [5:0]  m_otag;
    logic [31:0] m_owd;
    logic [1:0]  m_oexc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int op_size(input logic [7:0] op);
        if (op[7] || op[6] || op[2]) return 1;
        if (op[5] || op[4] || op[1]) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] load_value(input logic [7:0] op, input logic [1:0] off,
                                               input logic [31:0] rdata);
        int s;
        logic [63:0] mask, t;
        s = op_size(op);
        mask = (64'd1 << (8 * s)) - 64'd1;
        t = ({32'd0, rdata} >> (8 * off)) & mask;
        if ((op[7] || op[5]) && t[8 * s - 1]) t = t | ~mask;
        return t[31:0];
    endfunction

    task automatic model_reset();
        m_a_valid = 1'b0; m_a_op = '0; m_a_tag = '0; m_a_rf_we = 1'b0;
        m_a_sdata = '0; m_a_vaddr = '0;
        m_ov = 1'b0; m_otag = '0; m_orfwe = 1'b0; m_owd = '0; m_oexc = 2'b00;
        m_q.delete();
    endtask

    // Compare DUT against the model for the current cycle, then advance the model past the edge.
    task automatic model_cycle();
        int s;
        logic mis, full, e_req, fire, exc, leave, e_ready, pop, is_ld;
        logic [3:0] be;
        logic [31:0] wd;
        ent_t h;
        s = op_size(m_a_op);
        mis = (m_a_vaddr % 32'(s)) != 0;
        full = (m_q.size() == DEPTH);
        e_req = m_a_valid && !mis && !full && !flush;
        fire = e_req && mem_req_ready;
        exc = m_a_valid && mis && (m_q.size() == 0) && !flush;
        leave = fire || exc;
        e_ready = !flush && (!m_a_valid || leave);
        is_ld = |m_a_op[7:3];
        be = is_ld ? 4'b0000 : 4'(((1 << s) - 1) << m_a_vaddr[1:0]);
        if (is_ld) wd = 32'd0;
        else if (s == 1) wd = {24'd0, m_a_sdata[7:0]} * 32'h0101_0101;
        else if (s == 2) wd = {16'd0, m_a_sdata[15:0]} * 32'h0001_0001;
        else wd = m_a_sdata;

        chk("in_ready", in_ready, e_ready);
        chk("mem_req_valid", mem_req_valid, e_req);
        if (e_req) begin
            chk("mem_addr", mem_addr, m_a_vaddr);
            chk("mem_we", mem_we, be);
            chk("mem_wdata", mem_wdata, wd);
        end
        chk("out_valid", out_valid, m_ov);
        if (m_ov) begin
            chk("out_tag", out_tag, m_otag);
            chk("out_rf_we", out_rf_we, m_orfwe);
            chk("out_wdata", out_wdata, m_owd);
            chk("out_exc", out_exc, m_oexc);
        end

        if (mem_resp_valid && memq.size() != 0) void'(memq.pop_front());
        if (!resetn) begin
            model_reset();
            return;
        end

        pop = mem_resp_valid && (m_q.size() != 0);
        m_ov = 1'b0; m_otag = '0; m_orfwe = 1'b0; m_owd = '0; m_oexc = 2'b00;
        if (pop) begin
            h = m_q.pop_front();
            if (!h.kill && !flush) begin
                m_ov = 1'b1;
                m_otag = h.tag;
                m_orfwe = (|h.op[7:3]) && h.rf_we;
                m_owd = (|h.op[7:3]) ? load_value(h.op, h.off, mem_rdata) : 32'd0;
            end
        end else if (exc) begin
            m_ov = 1'b1;
            m_otag = m_a_tag;
            m_owd = m_a_vaddr;
            m_oexc = is_ld ? 2'b01 : 2'b10;
        end
        if (fire) begin
            m_q.push_back('{tag: m_a_tag, op: m_a_op, off: m_a_vaddr[1:0],
                            rf_we: m_a_rf_we, kill: 1'b0});
            memq.push_back(cyc + 1);
        end
        if (flush) foreach (m_q[i]) m_q[i].kill = 1'b1;

        if (flush) m_a_valid = 1'b0;
        else if (in_valid && e_ready) begin
            m_a_valid = 1'b1; m_a_op = in_op; m_a_tag = in_tag; m_a_rf_we = in_rf_we;
            m_a_sdata = in_sdata; m_a_vaddr = in_base + in_imm;
        end else if (leave) m_a_valid = 1'b0;
    endtask

    task automatic step();
        #1;
        model_cycle();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0; flush = 1'b0; mem_resp_valid = 1'b0; mem_req_ready = 1'b1;
    endtask

    task automatic offer(input logic [7:0] op, input logic [31:0] base, input logic [31:0] imm,
                         input logic [31:0] sdata, input logic [5:0] tag, input logic rf_we);
        in_valid = 1'b1; in_op = op; in_base = base; in_imm = imm;
        in_sdata = sdata; in_tag = tag; in_rf_we = rf_we;
    endtask

    task automatic one_load(input logic [7:0] op, input logic [31:0] base, input logic [31:0] imm,
                            input logic [5:0] tag, input logic [31:0] rdata,
                            input logic [31:0] want);
        idle(); offer(op, base, imm, 32'd0, tag, 1'b1); step();
        idle(); step();
        mem_resp_valid = 1'b1; mem_rdata = rdata; step();
        idle(); #1;
        chk("ld_valid", out_valid, 1'b1);
        chk("ld_data", out_wdata, want);
        chk("ld_tag", out_tag, tag);
        step();
    endtask

    initial begin
        resetn = 1'b1; idle(); offer(LW, 0, 0, 0, 0, 0); in_valid = 1'b0; mem_rdata = '0;
        model_reset();
        #1 resetn = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_req_valid", mem_req_valid, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        @(negedge clk);
        step(); step();
        resetn = 1'b1;
        step();

        // lw with memory responding two cycles after the request
        offer(LW, 32'h1000, 32'd4, 32'd0, 6'd5, 1'b1); step();
        idle(); #1;
        chk("lw_req_valid", mem_req_valid, 1'b1);
        chk("lw_addr", mem_addr, 32'h1004);
        chk("lw_we", mem_we, 4'b0000);
        step();
        step();
        mem_resp_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF; step();
        idle(); #1;
        chk("lw_valid", out_valid, 1'b1);
        chk("lw_data", out_wdata, 32'hDEAD_BEEF);
        chk("lw_rf_we", out_rf_we, 1'b1);
        chk("lw_tag", out_tag, 6'd5);
        step();

        // byte extraction and halfword store lane replication
        one_load(LB, 32'h1000, 32'd3, 6'd1, 32'h80FF_FFFF, 32'hFFFF_FF80);
        one_load(LBU, 32'h1000, 32'd3, 6'd2, 32'h80FF_FFFF, 32'h0000_0080);
        one_load(LH, 32'h1000, 32'd2, 6'd7, 32'h8001_7FFF, 32'hFFFF_8001);
        idle(); offer(SH, 32'h2000, 32'd2, 32'h0000_1234, 6'd3, 1'b1); step();
        idle(); #1;
        chk("sh_we", mem_we, 4'b1100);
        chk("sh_wdata", mem_wdata, 32'h1234_1234);
        step();
        mem_resp_valid = 1'b1; mem_rdata = 32'h5555_AAAA; step();
        idle(); #1;
        chk("sh_valid", out_valid, 1'b1);
        chk("sh_rf_we", out_rf_we, 1'b0);
        chk("sh_wdata_out", out_wdata, 32'd0);
        step();

        // FIFO full stall and release
        for (int i = 0; i < 5; i++) begin
            offer(LW, 32'h3000, 32'(4 * i), 32'd0, 6'(10 + i), 1'b1); step();
        end
        offer(LW, 32'h3100, 32'd0, 32'd0, 6'd15, 1'b1); #1;
        chk("full_in_ready", in_ready, 1'b0);
        chk("full_req_valid", mem_req_valid, 1'b0);
        step();
        mem_resp_valid = 1'b1; mem_rdata = 32'h0101_0101; step();
        mem_resp_valid = 1'b0; #1;
        chk("release_req", mem_req_valid, 1'b1);
        chk("release_addr", mem_addr, 32'h3010);
        chk("first_tag", out_tag, 6'd10);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_resp_valid = 1'b1; mem_rdata = $urandom; step();
            mem_resp_valid = 1'b0; #1;
            chk("order_tag", out_tag, 32'(11 + i));
            step();
        end

        // misaligned word behind two outstanding loads
        idle();
        offer(LW, 32'h100, 32'd0, 32'd0, 6'd20, 1'b1); step();
        offer(LW, 32'h104, 32'd0, 32'd0, 6'd21, 1'b1); step();
        offer(LW, 32'h1000, 32'd2, 32'd0, 6'd22, 1'b1); step();
        idle(); #1 chk("mis_no_req", mem_req_valid, 1'b0); step();
        mem_resp_valid = 1'b1; mem_rdata = 32'h2020_2020; step();
        idle(); #1 chk("mis_no_req2", mem_req_valid, 1'b0); step();
        mem_resp_valid = 1'b1; mem_rdata = 32'h2121_2121; step();
        idle(); #1 chk("mis_prior_tag", out_tag, 6'd21); step();
        #1;
        chk("mis_valid", out_valid, 1'b1);
        chk("mis_exc", out_exc, 2'b01);
        chk("mis_wdata", out_wdata, 32'h1002);
        chk("mis_rf_we", out_rf_we, 1'b0);
        chk("mis_tag", out_tag, 6'd22);
        step();

        // flush with three outstanding and one waiting in stage A
        offer(LW, 32'h400, 32'd0, 32'd0, 6'd30, 1'b1); step();
        offer(LW, 32'h404, 32'd0, 32'd0, 6'd31, 1'b1); step();
        offer(LW, 32'h408, 32'd0, 32'd0, 6'd32, 1'b1); step();
        offer(LW, 32'h40C, 32'd0, 32'd0, 6'd34, 1'b1); step();
        offer(LW, 32'h410, 32'd0, 32'd0, 6'd39, 1'b1); flush = 1'b1; #1;
        chk("flush_in_ready", in_ready, 1'b0);
        chk("flush_req_valid", mem_req_valid, 1'b0);
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            mem_resp_valid = 1'b1; mem_rdata = $urandom; step();
            mem_resp_valid = 1'b0; #1 chk("killed_silent", out_valid, 1'b0); step();
        end
        one_load(LW, 32'h500, 32'd0, 6'd33, 32'hCAFE_F00D, 32'hCAFE_F00D);

        // asynchronous reset mid-cycle with two loads outstanding
        idle();
        offer(LW, 32'h600, 32'd0, 32'd0, 6'd40, 1'b1); step();
        offer(LW, 32'h604, 32'd0, 32'd0, 6'd41, 1'b1); step();
        offer(LW, 32'h608, 32'd0, 32'd0, 6'd42, 1'b1); step();
        idle(); mem_resp_valid = 1'b1; mem_rdata = 32'h4040_4040;
        #1 model_cycle();
        @(posedge clk); cyc++;
        #2 chk("pre_rst_valid", out_valid, 1'b1);
        resetn = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_out_wdata", out_wdata, 32'd0);
        chk("arst_out_tag", out_tag, 32'd0);
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_req_valid", mem_req_valid, 1'b0);
        chk("arst_mem_addr", mem_addr, 32'd0);
        model_reset();
        @(negedge clk);
        step();
        resetn = 1'b1; step();
        idle(); #1 chk("late_resp_ignored", out_valid, 1'b0); step();
        step();

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            flush = ($urandom_range(0, 39) == 0);
            in_valid = ($urandom_range(0, 9) < 6);
            in_op = 8'h01 << $urandom_range(0, 7);
            in_base = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            in_imm = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7))
                                                 : 32'(4 * $urandom_range(0, 15));
            in_sdata = $urandom; in_tag = 6'($urandom); in_rf_we = 1'($urandom);
            mem_req_ready = ($urandom_range(0, 9) < 7);
            mem_rdata = $urandom;
            if (!flush && memq.size() != 0 && memq[0] <= cyc && $urandom_range(0, 9) < 6)
                mem_resp_valid = 1'b1;
            else if (memq.size() == 0 && $urandom_range(0, 19) == 0) mem_resp_valid = 1'b1;
            else mem_resp_valid = 1'b0;
            step();
        end
        idle(); in_valid = 1'b0;
        for (int n = 0; n < 200 && memq.size() != 0; n++) begin
            mem_rdata = $urandom;
            mem_resp_valid = (memq[0] <= cyc);
            step();
        end
        idle();
        step(); step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
